// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Loads that hit finish in the same cycle. Load misses fill the line from memory.
// Every store is written through to memory, and a store that hits also updates the line.
//
// state | meaning
// IDLE  | accept a core request; a load hit completes combinationally
// FILL  | memory read in flight for a load miss; line written on ack
// WTHRU | memory write in flight for a store; hit line merged on ack
module data_cache #(
  parameter int WD   = 32,
  parameter int SETS = 64,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [WD-1:0] cpu_addr,
  input  logic [2:0]    cpu_func3,
  input  logic [WD-1:0] cpu_wdata,
  output logic [WD-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [WD-1:0] mem_addr,
  output logic [WD-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [WD-1:0] mem_rdata,
  output logic [CW-1:0] hit_cnt,
  output logic [CW-1:0] miss_cnt
);

  localparam int IDX = $clog2(SETS);
  localparam int TW  = WD - IDX - 2;

  typedef enum logic [1:0] {IDLE, FILL, WTHRU} state_t;

  state_t state, state_n;

  logic [IDX-1:0] idx;
  logic [TW-1:0]  tag;
  logic [SETS-1:0] valid;
  logic [TW-1:0]  tag_array  [SETS];
  logic [WD-1:0]  data_array [SETS];
  logic           hit;
  logic [3:0]     st_be;
  logic [WD-1:0]  st_data;
  logic           hit_inc, miss_inc, fill_wr, store_wr;

  assign idx      = cpu_addr[IDX+1:2];
  assign tag      = cpu_addr[WD-1:IDX+2];
  assign hit      = valid[idx] && (tag_array[idx] == tag);
  assign mem_addr = {cpu_addr[WD-1:2], 2'b00};
  assign mem_wdata = st_data;
  assign mem_be   = (state == WTHRU) ? st_be : 4'b1111;

  // Store lane steering: replicate narrow data and enable only the addressed bytes.
  // Word accesses ignore the low address bits. Half-word accesses ignore bit 0.
  always_comb begin
    st_be   = 4'b1111;
    st_data = cpu_wdata;
    case (cpu_func3)
      3'b000, 3'b100: begin
        st_be   = 4'b0001 << cpu_addr[1:0];
        st_data = {4{cpu_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        st_be   = cpu_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // State register.
  // Reset abandons any in-flight transfer, so mem_req drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_n   = state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    fill_wr   = 1'b0;
    store_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_rd) begin
          if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_array[idx];
            hit_inc   = 1'b1;
          end else begin
            miss_inc = 1'b1;
            state_n  = FILL;
          end
        end else if (cpu_wr) begin
          state_n = WTHRU;
        end else begin
          cpu_ready = 1'b1;
        end
      end
      FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          cpu_ready = 1'b1;
          cpu_rdata = mem_rdata;
          fill_wr   = 1'b1;
          state_n   = IDLE;
        end
      end
      WTHRU: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          cpu_ready = 1'b1;
          store_wr  = hit;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Valid bits are the only line state that is cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          valid <= '0;
    else if (fill_wr) valid[idx] <= 1'b1;
  end

  // Tag and data arrays are not reset.
  // A store that misses leaves the line untouched because there is no write-allocate.
  always_ff @(posedge clk) begin
    if (fill_wr) begin
      tag_array[idx]  <= tag;
      data_array[idx] <= mem_rdata;
    end else if (store_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) data_array[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // Load hit/miss statistics. Both counters wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc)  hit_cnt  <= hit_cnt + CW'(1);
      if (miss_inc) miss_cnt <= miss_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache: load miss/hit, store lanes, no-allocate, conflicts, reset mid-fill.
module tb_data_cache;

  logic        clk, rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_func3;
  logic        cpu_ready, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [15:0] hit_cnt, miss_cnt;

  int checks = 0;
  int passed = 0;

  data_cache #(.WD(32), .SETS(64), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_func3(cpu_func3),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_func3 = f3; cpu_wdata = wd;
  endtask

  task automatic release_bus();
    cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (cpu_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", cpu_ready); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", mem_req); else passed++;
    checks++; if (cpu_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", cpu_rdata); else passed++;
    checks++; if ({hit_cnt, miss_cnt} !== 32'h0) $display("FAIL rst_cnt: got %h/%h want 0/0", hit_cnt, miss_cnt); else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_load_miss();
    start(1, 0, 32'h100, 3'b010, 0);
    #1;
    checks++; if (cpu_ready !== 1'b0) $display("FAIL miss_stall: got %0b want 0", cpu_ready); else passed++;
    tick();
    checks++; if ({mem_req, mem_we} !== 2'b10) $display("FAIL fill_req: got req=%0b we=%0b want 1/0", mem_req, mem_we); else passed++;
    checks++; if (mem_addr !== 32'h100) $display("FAIL fill_addr: got %h want 00000100", mem_addr); else passed++;
    checks++; if (mem_be !== 4'b1111) $display("FAIL fill_be: got %b want 1111", mem_be); else passed++;
    checks++; if (miss_cnt !== 16'd1) $display("FAIL miss_cnt1: got %0d want 1", miss_cnt); else passed++;
    tick(); tick();
    checks++; if ({mem_req, cpu_ready} !== 2'b10) $display("FAIL fill_hold: got req=%0b rdy=%0b want 1/0", mem_req, cpu_ready); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (cpu_ready !== 1'b1) $display("FAIL fill_ack_ready: got %0b want 1", cpu_ready); else passed++;
    checks++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL fill_rdata: got %h want deadbeef", cpu_rdata); else passed++;
    tick();
    release_bus();
    #1;
    checks++; if (mem_req !== 1'b0) $display("FAIL fill_done_req: got %0b want 0", mem_req); else passed++;
  endtask

  task automatic test_load_hit();
    start(1, 0, 32'h100, 3'b010, 0);
    #1;
    checks++; if (cpu_ready !== 1'b1) $display("FAIL hit_ready: got %0b want 1", cpu_ready); else passed++;
    checks++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL hit_rdata: got %h want deadbeef", cpu_rdata); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL hit_noreq: got %0b want 0", mem_req); else passed++;
    tick();
    release_bus();
    #1;
    checks++; if (hit_cnt !== 16'd1) $display("FAIL hit_cnt1: got %0d want 1", hit_cnt); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL hit_noreq2: got %0b want 0", mem_req); else passed++;
  endtask

  task automatic test_store_byte_hit();
    start(0, 1, 32'h102, 3'b000, 32'h000000AB);
    #1;
    checks++; if (cpu_ready !== 1'b0) $display("FAIL sb_stall: got %0b want 0", cpu_ready); else passed++;
    tick();
    checks++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL sb_req: got req=%0b we=%0b want 1/1", mem_req, mem_we); else passed++;
    checks++; if (mem_be !== 4'b0100) $display("FAIL sb_be: got %b want 0100", mem_be); else passed++;
    checks++; if (mem_wdata !== 32'hABABABAB) $display("FAIL sb_wdata: got %h want abababab", mem_wdata); else passed++;
    checks++; if (mem_addr !== 32'h100) $display("FAIL sb_addr: got %h want 00000100", mem_addr); else passed++;
    mem_ack = 1'b1;
    #1;
    checks++; if (cpu_ready !== 1'b1) $display("FAIL sb_ack_ready: got %0b want 1", cpu_ready); else passed++;
    tick();
    release_bus();
    #1;
    checks++; if ({hit_cnt, miss_cnt} !== {16'd1, 16'd1}) $display("FAIL sb_cnt: got %0d/%0d want 1/1", hit_cnt, miss_cnt); else passed++;
    start(1, 0, 32'h100, 3'b010, 0);
    #1;
    checks++; if (cpu_ready !== 1'b1) $display("FAIL sb_reload_ready: got %0b want 1", cpu_ready); else passed++;
    checks++; if (cpu_rdata !== 32'hDEABBEEF) $display("FAIL sb_merge: got %h want deabbeef", cpu_rdata); else passed++;
    tick();
    release_bus();
    #1;
    checks++; if (hit_cnt !== 16'd2) $display("FAIL hit_cnt2: got %0d want 2", hit_cnt); else passed++;
  endtask

  task automatic test_store_half_miss();
    start(0, 1, 32'h300, 3'b001, 32'hFFFF1234);
    tick();
    checks++; if (mem_be !== 4'b0011) $display("FAIL sh_be: got %b want 0011", mem_be); else passed++;
    checks++; if (mem_wdata !== 32'h12341234) $display("FAIL sh_wdata: got %h want 12341234", mem_wdata); else passed++;
    mem_ack = 1'b1;
    tick();
    release_bus();
    start(1, 0, 32'h300, 3'b010, 0);
    #1;
    checks++; if (cpu_ready !== 1'b0) $display("FAIL sh_noalloc: got ready=%0b want 0", cpu_ready); else passed++;
    tick();
    checks++; if (miss_cnt !== 16'd2) $display("FAIL miss_cnt2: got %0d want 2", miss_cnt); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h55AA0000;
    tick();
    release_bus();
    // Upper half-word store hit, odd address: bit 0 ignored, lanes 3:2
    start(0, 1, 32'h303, 3'b101, 32'h0000BEEF);
    tick();
    checks++; if (mem_be !== 4'b1100) $display("FAIL sh_hi_be: got %b want 1100", mem_be); else passed++;
    mem_ack = 1'b1;
    tick();
    release_bus();
    start(1, 0, 32'h300, 3'b010, 0);
    #1;
    checks++; if (cpu_rdata !== 32'hBEEF0000) $display("FAIL sh_hi_merge: got %h want beef0000", cpu_rdata); else passed++;
    tick();
    release_bus();
  endtask

  task automatic test_conflict();
    start(1, 0, 32'h100, 3'b010, 0);
    #1;
    checks++; if (cpu_ready !== 1'b0) $display("FAIL cf_miss1: got ready=%0b want 0", cpu_ready); else passed++;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    release_bus();
    start(1, 0, 32'h200, 3'b010, 0);
    #1;
    checks++; if (cpu_ready !== 1'b0) $display("FAIL cf_miss2: got ready=%0b want 0", cpu_ready); else passed++;
    tick();
    checks++; if (mem_addr !== 32'h200) $display("FAIL cf_addr: got %h want 00000200", mem_addr); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    tick();
    release_bus();
    start(1, 0, 32'h100, 3'b010, 0);
    #1;
    checks++; if (cpu_ready !== 1'b0) $display("FAIL cf_evicted: got ready=%0b want 0", cpu_ready); else passed++;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    release_bus();
    #1;
    checks++; if ({hit_cnt, miss_cnt} !== {16'd3, 16'd5}) $display("FAIL cf_cnt: got %0d/%0d want 3/5", hit_cnt, miss_cnt); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    start(1, 0, 32'h200, 3'b010, 0);
    tick();
    checks++; if (mem_req !== 1'b1) $display("FAIL rf_req: got %0b want 1", mem_req); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) $display("FAIL rf_async: got %0b want 0", mem_req); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    tick();
    rst = 1'b0; cpu_rd = 1'b0;
    #1;
    checks++; if ({mem_req, cpu_ready} !== 2'b01) $display("FAIL rf_late_ack: got req=%0b rdy=%0b want 0/1", mem_req, cpu_ready); else passed++;
    tick();
    mem_ack = 1'b0;
    checks++; if ({hit_cnt, miss_cnt} !== 32'h0) $display("FAIL rf_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt); else passed++;
    start(1, 0, 32'h100, 3'b010, 0);
    #1;
    checks++; if (cpu_ready !== 1'b0) $display("FAIL rf_invalid: got ready=%0b want 0", cpu_ready); else passed++;
    tick();
    checks++; if ({mem_req, miss_cnt} !== {1'b1, 16'd1}) $display("FAIL rf_refill: got req=%0b miss=%0d want 1/1", mem_req, miss_cnt); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    #1;
    checks++; if (cpu_rdata !== 32'h77777777) $display("FAIL rf_rdata: got %h want 77777777", cpu_rdata); else passed++;
    tick();
    release_bus();
  endtask

  initial begin
    rst = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_func3 = 3'b010; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_byte_hit();
    test_store_half_miss();
    test_conflict();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
